// File: rtl/ili9225_spi_controller.sv
// ILI9225 SPI write-only master: plays the init ROM, sends GRAM-write (0x0022), then streams RGB565 pixels.
// Define FAST_SIM_EN to shrink every ms delay (reset wait and ROM DLY entries) to 16 clk cycles.
module ili9225_spi_controller #(
    parameter int CLK_FREQ_HZ  = 25_000_000,
    parameter int RST_DELAY_MS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] input_data,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        spi_dc,
    output logic        data_clk
);
    // state    | meaning
    // RST_WAIT | post-reset delay before the first SPI word
    // INIT     | playing ROM entry rom_idx (CMD/DATA word or ms delay)
    // GRAM_CMD | sending the GRAM-write command 0x0022
    // PIXEL    | streaming pixel words back to back, cs held low
    // DONE     | frame finished, idle until reset
    typedef enum logic [2:0] {RST_WAIT, INIT, GRAM_CMD, PIXEL, DONE} state_t;

    localparam logic [1:0] K_CMD  = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_DLY  = 2'd2;
    localparam logic [5:0] ROM_LAST = 6'd56;
`ifdef FAST_SIM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int MS_CYC  = CLK_FREQ_HZ / 1000;
    localparam int MAX_MS  = (RST_DELAY_MS > 50) ? RST_DELAY_MS : 50;
    localparam int MAX_CYC = FAST ? 16 : MAX_MS * MS_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    // Down-counter load value for an N-ms wait: the wait lasts (load + 1) cycles.
    function automatic logic [TW-1:0] ms_load(input int ms);
        int c;
        c = FAST ? 16 : ms * MS_CYC;
        return (c > 0) ? TW'(c - 1) : '0;
    endfunction

    localparam logic [TW-1:0] RST_LOAD = ms_load(RST_DELAY_MS);

    // {kind, value}; for DLY entries value is the delay in ms.
    function automatic logic [17:0] rom_entry(input logic [5:0] idx);
        logic [17:0] e;
        case (idx)
            6'd0:  e = {K_CMD, 16'h0010};  6'd1:  e = {K_DATA, 16'h0000};
            6'd2:  e = {K_CMD, 16'h0011};  6'd3:  e = {K_DATA, 16'h0000};
            6'd4:  e = {K_CMD, 16'h0012};  6'd5:  e = {K_DATA, 16'h0000};
            6'd6:  e = {K_CMD, 16'h0013};  6'd7:  e = {K_DATA, 16'h0000};
            6'd8:  e = {K_CMD, 16'h0014};  6'd9:  e = {K_DATA, 16'h0000};
            6'd10: e = {K_DLY, 16'd40};
            6'd11: e = {K_CMD, 16'h0011};  6'd12: e = {K_DATA, 16'h0018};
            6'd13: e = {K_CMD, 16'h0012};  6'd14: e = {K_DATA, 16'h6121};
            6'd15: e = {K_CMD, 16'h0013};  6'd16: e = {K_DATA, 16'h006F};
            6'd17: e = {K_CMD, 16'h0014};  6'd18: e = {K_DATA, 16'h495F};
            6'd19: e = {K_CMD, 16'h0010};  6'd20: e = {K_DATA, 16'h0800};
            6'd21: e = {K_DLY, 16'd10};
            6'd22: e = {K_CMD, 16'h0011};  6'd23: e = {K_DATA, 16'h103B};
            6'd24: e = {K_DLY, 16'd50};
            6'd25: e = {K_CMD, 16'h0001};  6'd26: e = {K_DATA, 16'h011C};
            6'd27: e = {K_CMD, 16'h0002};  6'd28: e = {K_DATA, 16'h0100};
            6'd29: e = {K_CMD, 16'h0003};  6'd30: e = {K_DATA, 16'h1030};
            6'd31: e = {K_CMD, 16'h0007};  6'd32: e = {K_DATA, 16'h0000};
            6'd33: e = {K_CMD, 16'h0008};  6'd34: e = {K_DATA, 16'h0808};
            6'd35: e = {K_CMD, 16'h000B};  6'd36: e = {K_DATA, 16'h1100};
            6'd37: e = {K_CMD, 16'h000C};  6'd38: e = {K_DATA, 16'h0000};
            6'd39: e = {K_CMD, 16'h000F};  6'd40: e = {K_DATA, 16'h0D01};
            6'd41: e = {K_CMD, 16'h0015};  6'd42: e = {K_DATA, 16'h0020};
            6'd43: e = {K_CMD, 16'h0020};  6'd44: e = {K_DATA, 16'h0000};
            6'd45: e = {K_CMD, 16'h0021};  6'd46: e = {K_DATA, 16'h0000};
            6'd47: e = {K_CMD, 16'h0036};  6'd48: e = {K_DATA, 16'h00AF};
            6'd49: e = {K_CMD, 16'h0037};  6'd50: e = {K_DATA, 16'h0000};
            6'd51: e = {K_CMD, 16'h0038};  6'd52: e = {K_DATA, 16'h00DB};
            6'd53: e = {K_CMD, 16'h0039};  6'd54: e = {K_DATA, 16'h0000};
            6'd55: e = {K_CMD, 16'h0007};  6'd56: e = {K_DATA, 16'h1017};
            default: e = {K_CMD, 16'h0000};
        endcase
        return e;
    endfunction

    state_t        state, state_n;
    logic [5:0]    phase, phase_n;
    logic [15:0]   shreg, shreg_n;
    logic          dc_r, dc_n;
    logic [5:0]    rom_idx, rom_idx_n;
    logic [TW-1:0] timer, timer_n;
    logic [17:0]   entry, next_entry, ld;
    logic          do_load, advance, step, pix_load, word_active;

    assign entry      = rom_entry(rom_idx);
    assign next_entry = rom_entry(rom_idx + 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_WAIT;
            phase   <= '0;
            shreg   <= '0;
            dc_r    <= 1'b0;
            rom_idx <= '0;
            timer   <= RST_LOAD;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            shreg   <= shreg_n;
            dc_r    <= dc_n;
            rom_idx <= rom_idx_n;
            timer   <= timer_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        shreg_n   = shreg;
        dc_n      = dc_r;
        rom_idx_n = rom_idx;
        timer_n   = timer;
        ld        = entry;
        do_load   = 1'b0;
        advance   = 1'b0;
        step      = 1'b0;
        pix_load  = 1'b0;
        case (state)
            RST_WAIT: begin
                if (timer == '0) begin
                    state_n = INIT;
                    do_load = 1'b1;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            INIT: begin
                if (entry[17:16] == K_DLY) begin
                    if (timer == '0) advance = 1'b1;
                    else             timer_n = timer - TW'(1);
                end else if (phase == 6'd33) begin
                    advance = 1'b1;
                end else begin
                    step = 1'b1;
                end
                if (advance) begin
                    if (rom_idx == ROM_LAST) begin
                        state_n = GRAM_CMD;
                        shreg_n = 16'h0022;
                        dc_n    = 1'b0;
                        phase_n = '0;
                    end else begin
                        rom_idx_n = rom_idx + 6'd1;
                        ld        = next_entry;
                        do_load   = 1'b1;
                    end
                end
            end
            GRAM_CMD: begin
                if (phase == 6'd33) begin
                    state_n  = PIXEL;
                    pix_load = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            PIXEL: begin
                if (phase == 6'd32) pix_load = 1'b1;
                else                step = 1'b1;
            end
            DONE:    ;
            default: state_n = RST_WAIT;
        endcase

        // Shift on the falling sck step so mosi changes while sck is low.
        if (step) begin
            phase_n = phase + 6'd1;
            if (phase[0]) shreg_n = {shreg[14:0], 1'b0};
        end
        if (do_load) begin
            if (ld[17:16] == K_DLY) begin
                timer_n = ms_load(int'(ld[15:0]));
            end else begin
                shreg_n = ld[15:0];
                dc_n    = (ld[17:16] == K_DATA);
                phase_n = '0;
            end
        end
        // The next pixel setup cycle is entered here; frame_done ends the stream instead.
        if (pix_load) begin
            if (frame_done) begin
                state_n = DONE;
            end else begin
                shreg_n = input_data;
                dc_n    = 1'b1;
                phase_n = '0;
            end
        end
    end

    assign word_active = ((state == INIT) && (entry[17:16] != K_DLY) && (phase <= 6'd32)) ||
                         ((state == GRAM_CMD) && (phase <= 6'd32)) ||
                         (state == PIXEL);
    assign spi_cs   = ~word_active;
    assign spi_sck  = word_active & phase[0];
    assign spi_mosi = word_active & shreg[15];
    assign spi_dc   = word_active & dc_r;
    assign data_clk = (state == PIXEL) && (phase == 6'd0);

endmodule

// File: tb/tb_ili9225_spi_controller.sv
// Bench for ili9225_spi_controller: decodes the SPI pins into words and checks them against a ROM/pixel model.
// Delay expectations follow FAST_SIM_EN when it is defined for the whole build.
module tb_ili9225_spi_controller;
    localparam int CLK_HZ = 16000;   // 16 cycles per ms, so the reset wait is 16 cycles in either build
    localparam int N_INIT = 55;      // 54 init words plus the GRAM-write command

    // reg/data pairs in playback order
    localparam logic [31:0] PAIRS [27] = '{
        32'h0010_0000, 32'h0011_0000, 32'h0012_0000, 32'h0013_0000, 32'h0014_0000,
        32'h0011_0018, 32'h0012_6121, 32'h0013_006F, 32'h0014_495F, 32'h0010_0800,
        32'h0011_103B,
        32'h0001_011C, 32'h0002_0100, 32'h0003_1030, 32'h0007_0000, 32'h0008_0808,
        32'h000B_1100, 32'h000C_0000, 32'h000F_0D01, 32'h0015_0020, 32'h0020_0000,
        32'h0021_0000, 32'h0036_00AF, 32'h0037_0000, 32'h0038_00DB, 32'h0039_0000,
        32'h0007_1017};

    typedef struct {logic dc; logic [15:0] val; int start; int gap; bit dc_ok;} word_t;
    typedef struct {logic dc; logic [15:0] val; int gap; int period;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_done = 1'b0;
    logic [15:0] input_data = '0;
    logic spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

    word_t       wq[$];
    int          pq[$];
    logic [15:0] pixq[$];
    exp_t        expq[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, stray = 0, dclk_wide = 0;

    ili9225_spi_controller #(.CLK_FREQ_HZ(CLK_HZ), .RST_DELAY_MS(1)) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .input_data(input_data),
        .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_dc(spi_dc),
        .data_clk(data_clk));

    always #5 clk = ~clk;

    function automatic int dly_cyc(input int ms);
`ifdef FAST_SIM_EN
        return (ms > 0) ? 16 : 0;
`else
        return ms * (CLK_HZ / 1000);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pin decoder: one word per 16 sck rises while cs is low, sampled on the falling clock edge.
    initial begin : monitor
        int bitn, gap_run, last_gap, cur_start;
        logic [15:0] sr;
        logic cur_dc, sck_q, dclk_q, cs_q;
        bit dc_ok;
        word_t w;
        bitn = 0; gap_run = 0; last_gap = 0; cur_start = 0; sr = '0;
        cur_dc = 1'b0; sck_q = 1'b0; dclk_q = 1'b0; cs_q = 1'b1; dc_ok = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                bitn = 0; gap_run = 0; sck_q = 1'b0; dclk_q = 1'b0; cs_q = 1'b1;
            end else begin
                if (spi_sck && !sck_q) begin
                    if (spi_cs) stray++;
                    else begin
                        if (bitn == 0) begin
                            cur_start = cyc - 1; cur_dc = spi_dc; dc_ok = 1'b1;
                        end else if (spi_dc !== cur_dc) dc_ok = 1'b0;
                        sr = {sr[14:0], spi_mosi};
                        bitn++;
                        if (bitn == 16) begin
                            w.dc = cur_dc; w.val = sr; w.start = cur_start; w.gap = last_gap; w.dc_ok = dc_ok;
                            wq.push_back(w);
                            bitn = 0;
                        end
                    end
                end
                if (spi_cs) gap_run++;
                else begin
                    if (cs_q) last_gap = gap_run;
                    else if (bitn == 0 && !spi_sck) last_gap = 0;
                    gap_run = 0;
                end
                if (data_clk) begin
                    if (dclk_q) dclk_wide++;
                    else pq.push_back(cyc);
                end
                sck_q = spi_sck; dclk_q = data_clk; cs_q = spi_cs;
            end
        end
    end

    task automatic build_model();
        int pre;
        logic [31:0] pr;
        exp_t e;
        pre = 0;
        expq.delete();
        for (int p = 0; p < 27; p++) begin
            pr = PAIRS[p];
            e.dc = 1'b0; e.val = pr[31:16]; e.gap = 1 + pre; e.period = 34 + pre;
            expq.push_back(e);
            e.dc = 1'b1; e.val = pr[15:0]; e.gap = 1; e.period = 34;
            expq.push_back(e);
            pre = (p == 4) ? dly_cyc(40) : (p == 9) ? dly_cyc(10) : (p == 10) ? dly_cyc(50) : 0;
        end
        e.dc = 1'b0; e.val = 16'h0022; e.gap = 1; e.period = 34;
        expq.push_back(e);
        foreach (pixq[i]) begin
            e.dc = 1'b1; e.val = pixq[i];
            e.gap = (i == 0) ? 1 : 0;
            e.period = (i == 0) ? 34 : 33;
            expq.push_back(e);
        end
    endtask

    task automatic run_frame(input int npix, input int abort_at, input bit fixed);
        int k, pulses, budget, idle_bad;
        wq.delete(); pq.delete(); pixq.delete();
        stray = 0; dclk_wide = 0;
        frame_done = 1'b0;
        input_data = fixed ? 16'hF800 : 16'($urandom);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (spi_cs && k < 100);
        chk("startup_latency", k, 16);
        frame_done = 1'b1;               // must be ignored outside PIXEL
        repeat (200) @(posedge clk);
        frame_done = 1'b0;
        budget = 0;
        while (wq.size() < N_INIT && budget < 20000) begin @(posedge clk); budget++; end
        chk("init_words_in_time", wq.size() >= N_INIT, 1);
        pulses = 0; budget = 0;
        while (pulses < npix && budget < npix * 40 + 200) begin
            @(posedge clk); #1; budget++;
            if (data_clk) begin
                pixq.push_back(input_data);
                pulses++;
                if (pulses == abort_at) begin
                    repeat (7) @(posedge clk);
                    #3 rst = 1'b1;
                    #1 chk("abort_reset_outputs", {spi_cs, spi_sck, spi_mosi, spi_dc, data_clk}, 5'b10000);
                    return;
                end
                if (!fixed) input_data = 16'($urandom);
                if (pulses == npix) frame_done = 1'b1;
            end
        end
        chk("pulses_in_time", pulses, npix);
        budget = 0;
        while (wq.size() < N_INIT + npix && budget < 200) begin @(posedge clk); budget++; end
        idle_bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (spi_cs !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0 || data_clk !== 1'b0) idle_bad++;
        end
        chk("done_idle", idle_bad, 0);
        chk("pulse_count", pq.size(), npix);
        chk("data_clk_width", dclk_wide, 0);
        chk("sck_with_cs_high", stray, 0);
        build_model();
        chk("word_count", wq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < wq.size(); i++) begin
            chk($sformatf("w%0d_dc_val", i), {wq[i].dc, wq[i].val}, {expq[i].dc, expq[i].val});
            chk($sformatf("w%0d_dc_stable", i), wq[i].dc_ok, 1);
            if (i > 0) begin
                chk($sformatf("w%0d_cs_gap", i), wq[i].gap, expq[i].gap);
                chk($sformatf("w%0d_period", i), wq[i].start - wq[i-1].start, expq[i].period);
            end
        end
        for (int i = 0; i < pq.size() && N_INIT + i < wq.size(); i++)
            chk($sformatf("pulse%0d_at_setup", i), pq[i], wq[N_INIT + i].start);
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("reset_outputs", {spi_cs, spi_sck, spi_mosi, spi_dc, data_clk}, 5'b10000);
        run_frame(5, 0, 1'b1);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        run_frame(10, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("held_reset_outputs", {spi_cs, spi_sck, spi_mosi, spi_dc, data_clk}, 5'b10000);
        run_frame(int'($urandom_range(1, 12)), 0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
